// File: rtl/alu_muldiv_seq_if.sv
// ALU opcode package plus the pipeline-side request/response bundle for the
// iterative multiply/divide sequencer.
package alu_muldiv_pkg;
    typedef enum logic [3:0] {
        ALU_SUM = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_opcode_t;
endpackage

interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_dbz;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_dbz
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_dbz
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// RV32M multiply/divide sequencer that borrows the execute-stage ALU (SUM/SUB)
// for shift-add multiply and restoring divide. Define MULDIV_EARLY_OUT_EN to let
// MUL finish as soon as the remaining multiplier bits are all zero.
//
// state  | meaning
// IDLE   | ready for a request, ALU driven with SUM 0+0
// NEG_A  | signed divide: take magnitude of dividend
// NEG_B  | signed divide: take magnitude of divisor, record result signs
// ITER   | one multiply or divide step per cycle, XLEN steps
// FIX_Q  | signed divide: negate quotient if signs differed
// FIX_R  | signed divide: negate remainder if dividend was negative
// DONE   | response valid, held until accepted
module alu_muldiv_seq
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    alu_muldiv_seq_if.slave      bus,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output alu_opcode_t          alu_op,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [3:0]           alu_status
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG_A = 3'd1,
        S_NEG_B = 3'd2,
        S_ITER  = 3'd3,
        S_FIX_Q = 3'd4,
        S_FIX_R = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t state, state_n;

    // acc: product accumulator / partial remainder
    // lo : multiplier / dividend shifting into quotient
    // opb: multiplicand / divisor
    logic [XLEN-1:0]       acc, lo, opb;
    logic [ITER_CNT_W-1:0] cnt;
    logic                  is_div, is_signed, want_rem, dbz;
    logic                  a_neg, sign_q, sign_r;

    logic                  req_fire;
    logic                  req_dbz;
    logic                  req_signed;
    logic [XLEN-1:0]       trial;
    logic                  div_accept;
    logic                  iter_last;
    logic                  mul_early;
    logic                  status_unused;

    assign status_unused = ^{alu_status[3:2], alu_status[0]};

    assign req_fire   = bus.req_valid && (state == S_IDLE) && !flush;
    assign req_dbz    = bus.req_op[2] && (bus.req_b == '0);
    assign req_signed = bus.req_op[2] && !bus.req_op[0];

    assign trial      = {acc[XLEN-2:0], lo[XLEN-1]};
    // A set remainder MSB means the shifted 33-bit trial always exceeds the divisor.
    assign div_accept = !alu_status[1] || acc[XLEN-1];
    assign iter_last  = (cnt == ITER_CNT_W'(XLEN - 1));

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_early  = !is_div && (lo[XLEN-1:1] == '0);
`else
    assign mul_early  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        alu_op  = ALU_SUM;
        alu_a   = '0;
        alu_b   = '0;
        case (state)
            S_IDLE: begin
                if (req_fire) begin
                    if (req_dbz)         state_n = S_DONE;
                    else if (req_signed) state_n = S_NEG_A;
                    else                 state_n = S_ITER;
                end
            end
            S_NEG_A: begin
                alu_op  = ALU_SUB;
                alu_b   = lo;
                state_n = S_NEG_B;
            end
            S_NEG_B: begin
                alu_op  = ALU_SUB;
                alu_b   = opb;
                state_n = S_ITER;
            end
            S_ITER: begin
                if (is_div) begin
                    alu_op = ALU_SUB;
                    alu_a  = trial;
                    alu_b  = opb;
                end else begin
                    alu_op = ALU_SUM;
                    alu_a  = acc;
                    alu_b  = opb;
                end
                if (iter_last || mul_early)
                    state_n = is_signed ? S_FIX_Q : S_DONE;
            end
            S_FIX_Q: begin
                alu_op  = ALU_SUB;
                alu_b   = lo;
                state_n = S_FIX_R;
            end
            S_FIX_R: begin
                alu_op  = ALU_SUB;
                alu_b   = acc;
                state_n = S_DONE;
            end
            S_DONE: begin
                if (bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (flush && (state != S_IDLE)) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            lo        <= '0;
            opb       <= '0;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            want_rem  <= 1'b0;
            dbz       <= 1'b0;
            a_neg     <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_fire) begin
                        is_div    <= bus.req_op[2];
                        is_signed <= req_signed;
                        want_rem  <= bus.req_op[2] && bus.req_op[1];
                        cnt       <= '0;
                        a_neg     <= 1'b0;
                        sign_q    <= 1'b0;
                        sign_r    <= 1'b0;
                        dbz       <= req_dbz;
                        if (req_dbz) begin
                            acc <= bus.req_a;
                            lo  <= '1;
                            opb <= '0;
                        end else if (bus.req_op[2]) begin
                            acc <= '0;
                            lo  <= bus.req_a;
                            opb <= bus.req_b;
                        end else begin
                            acc <= '0;
                            lo  <= bus.req_b;
                            opb <= bus.req_a;
                        end
                    end
                end
                S_NEG_A: begin
                    if (lo[XLEN-1]) lo <= alu_result;
                    a_neg <= lo[XLEN-1];
                end
                S_NEG_B: begin
                    if (opb[XLEN-1]) opb <= alu_result;
                    sign_q <= a_neg ^ opb[XLEN-1];
                    sign_r <= a_neg;
                end
                S_ITER: begin
                    cnt <= cnt + ITER_CNT_W'(1);
                    if (is_div) begin
                        acc <= div_accept ? alu_result : trial;
                        lo  <= {lo[XLEN-2:0], div_accept};
                    end else begin
                        if (lo[0]) acc <= alu_result;
                        opb <= opb << 1;
                        lo  <= lo >> 1;
                    end
                end
                S_FIX_Q: begin
                    if (sign_q) lo <= alu_result;
                end
                S_FIX_R: begin
                    if (sign_r) acc <= alu_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_DONE);
    assign bus.rsp_dbz   = (state == S_DONE) && dbz;
    assign bus.rsp_data  = (state != S_DONE) ? '0 :
                           (is_div && !want_rem) ? lo : acc;

endmodule
